axi4_burst_slave: RTL and testbench

AXI4 memory-mapped slave with full burst support: parametrised data/address/ID widths and depth, FIXED/INCR/WRAP bursts, WSTRB byte enables, and per-burst error decode. Replaces the fixed-width single-mode slave behind the interconnect. Read and write channels run concurrently against an internal two-port word array.

---
 rtl/axi4_burst_slave.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_axi4_burst_slave.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_burst_slave.sv
// axi4_burst_slave: AXI4 memory slave, FIXED/INCR/WRAP bursts, WSTRB, per-burst error decode.
// Ports: ACLK/ARESET, AW/W/B write channels, AR/R read channels. Option macro: AXI4_BURST_SLAVE_WRAP_EN.
module axi4_burst_slave #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int ID_WIDTH     = 4,
    parameter int MEMORY_DEPTH = 1024
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [ID_WIDTH-1:0]     AWID,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [7:0]              AWLEN,
    input  logic [2:0]              AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [ID_WIDTH-1:0]     BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ID_WIDTH-1:0]     ARID,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [7:0]              ARLEN,
    input  logic [2:0]              ARSIZE,
    input  logic [1:0]              ARBURST,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [ID_WIDTH-1:0]     RID,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int BL = $clog2(NB);
    localparam int IW = $clog2(MEMORY_DEPTH);
    localparam int EW = ADDR_WIDTH + 17;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

    // Classify a whole burst; hi is the highest beat address touched.
    function automatic logic [1:0] classify(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [7:0]            len,
        input logic [2:0]            sz,
        input logic [1:0]            bt
    );
        logic [EW-1:0] ax, total, hi;
        logic          bad;
        ax    = EW'(a);
        total = (EW'(len) + EW'(1)) << sz;
        hi    = ax;
        bad   = (sz > 3'(BL));
        case (bt)
            2'b00: hi = ax;
            2'b01: begin
                hi = ax + (EW'(len) << sz);
                if ((ax & EW'(12'hFFF)) + total > EW'(4096))
                    bad = 1'b1;
            end
`ifdef AXI4_BURST_SLAVE_WRAP_EN
            2'b10: begin
                hi = (ax & ~(total - EW'(1))) + total - EW'(1);
                if (!(len == 8'd1 || len == 8'd3 ||
                      len == 8'd7 || len == 8'd15))
                    bad = 1'b1;
                if ((ax & ((EW'(1) << sz) - EW'(1))) != '0)
                    bad = 1'b1;
            end
`endif
            default: bad = 1'b1;
        endcase
        if (bad)
            classify = SLVERR;
        else if ((hi >> BL) >= EW'(MEMORY_DEPTH))
            classify = DECERR;
        else
            classify = OKAY;
    endfunction

    // ---------------- write side ----------------
    w_state_t              w_state;
    logic [ADDR_WIDTH-1:0] w_addr, w_next;
    logic [7:0]            w_len, w_cnt;
    logic [2:0]            w_size;
    logic [1:0]            w_burst, w_err;
    logic                  w_last_bad;
    logic                  w_beat;
    logic [IW-1:0]         w_idx;
`ifdef AXI4_BURST_SLAVE_WRAP_EN
    logic [ADDR_WIDTH-1:0] w_mask;
`endif

    always_comb begin
        w_next = w_addr + (ADDR_WIDTH'(1) << w_size);
`ifdef AXI4_BURST_SLAVE_WRAP_EN
        if (w_burst == 2'b10)
            w_next = (w_addr & ~w_mask) | (w_next & w_mask);
`endif
        if (w_burst == 2'b00)
            w_next = w_addr;
    end

    assign w_beat = WVALID && WREADY;
    assign w_idx  = IW'(w_addr >> BL);

    always_ff @(posedge ACLK) begin
        if (!ARESET && w_beat && w_err == OKAY)
            for (int i = 0; i < NB; i++)
                if (WSTRB[i])
                    mem[w_idx][8*i +: 8] <= WDATA[8*i +: 8];
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state    <= W_IDLE;
            AWREADY    <= 1'b0;
            WREADY     <= 1'b0;
            BVALID     <= 1'b0;
            BID        <= '0;
            BRESP      <= OKAY;
            w_addr     <= '0;
            w_len      <= '0;
            w_cnt      <= '0;
            w_size     <= '0;
            w_burst    <= '0;
            w_err      <= OKAY;
            w_last_bad <= 1'b0;
`ifdef AXI4_BURST_SLAVE_WRAP_EN
            w_mask     <= '0;
`endif
        end else begin
            unique case (w_state)
                W_IDLE: begin
                    if (AWVALID && AWREADY) begin
                        BID        <= AWID;
                        w_addr     <= AWADDR;
                        w_len      <= AWLEN;
                        w_size     <= AWSIZE;
                        w_burst    <= AWBURST;
                        w_cnt      <= '0;
                        w_last_bad <= 1'b0;
                        w_err      <= classify(AWADDR, AWLEN, AWSIZE, AWBURST);
`ifdef AXI4_BURST_SLAVE_WRAP_EN
                        w_mask     <= ADDR_WIDTH'(((EW'(AWLEN) + EW'(1)) << AWSIZE) - EW'(1));
`endif
                        AWREADY    <= 1'b0;
                        WREADY     <= 1'b1;
                        w_state    <= W_DATA;
                    end else begin
                        AWREADY <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_beat) begin
                        w_addr <= w_next;
                        w_cnt  <= w_cnt + 8'd1;
                        if (w_cnt == w_len) begin
                            WREADY  <= 1'b0;
                            BVALID  <= 1'b1;
                            w_state <= W_RESP;
                            // A misplaced WLAST only matters for an otherwise clean burst.
                            if (w_err != OKAY)
                                BRESP <= w_err;
                            else if (w_last_bad || !WLAST)
                                BRESP <= SLVERR;
                            else
                                BRESP <= OKAY;
                        end else if (WLAST) begin
                            w_last_bad <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        BVALID  <= 1'b0;
                        AWREADY <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // ---------------- read side ----------------
    r_state_t              r_state;
    logic [ADDR_WIDTH-1:0] r_addr, r_next, r_rd_addr;
    logic [7:0]            r_len, r_cnt;
    logic [2:0]            r_size;
    logic [1:0]            r_burst, r_err;
    logic                  r_beat;
    logic [IW-1:0]         r_idx;
`ifdef AXI4_BURST_SLAVE_WRAP_EN
    logic [ADDR_WIDTH-1:0] r_mask;
`endif

    always_comb begin
        r_next = r_addr + (ADDR_WIDTH'(1) << r_size);
`ifdef AXI4_BURST_SLAVE_WRAP_EN
        if (r_burst == 2'b10)
            r_next = (r_addr & ~r_mask) | (r_next & r_mask);
`endif
        if (r_burst == 2'b00)
            r_next = r_addr;
    end

    // The fetch cycle reads the first beat; later beats read ahead on each handshake.
    assign r_rd_addr = (r_state == R_FETCH) ? r_addr : r_next;
    assign r_idx     = IW'(r_rd_addr >> BL);
    assign r_beat    = RVALID && RREADY;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= R_IDLE;
            ARREADY <= 1'b0;
            RVALID  <= 1'b0;
            RID     <= '0;
            RDATA   <= '0;
            RRESP   <= OKAY;
            RLAST   <= 1'b0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_err   <= OKAY;
`ifdef AXI4_BURST_SLAVE_WRAP_EN
            r_mask  <= '0;
`endif
        end else begin
            unique case (r_state)
                R_IDLE: begin
                    if (ARVALID && ARREADY) begin
                        RID     <= ARID;
                        r_addr  <= ARADDR;
                        r_len   <= ARLEN;
                        r_size  <= ARSIZE;
                        r_burst <= ARBURST;
                        r_cnt   <= '0;
                        r_err   <= classify(ARADDR, ARLEN, ARSIZE, ARBURST);
`ifdef AXI4_BURST_SLAVE_WRAP_EN
                        r_mask  <= ADDR_WIDTH'(((EW'(ARLEN) + EW'(1)) << ARSIZE) - EW'(1));
`endif
                        ARREADY <= 1'b0;
                        r_state <= R_FETCH;
                    end else begin
                        ARREADY <= 1'b1;
                    end
                end
                R_FETCH: begin
                    RVALID  <= 1'b1;
                    RRESP   <= r_err;
                    RLAST   <= (r_len == 8'd0);
                    RDATA   <= (r_err == OKAY) ? mem[r_idx] : '0;
                    r_state <= R_DATA;
                end
                R_DATA: begin
                    if (r_beat) begin
                        if (r_cnt == r_len) begin
                            RVALID  <= 1'b0;
                            RLAST   <= 1'b0;
                            RDATA   <= '0;
                            RRESP   <= OKAY;
                            ARREADY <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            r_addr <= r_next;
                            r_cnt  <= r_cnt + 8'd1;
                            RLAST  <= (r_cnt + 8'd1 == r_len);
                            RDATA  <= (r_err == OKAY) ? mem[r_idx] : '0;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_burst_slave.sv
// tb_axi4_burst_slave: directed bench for axi4_burst_slave (32-bit bus, 1024 words).
// Honours AXI4_BURST_SLAVE_WRAP_EN for the WRAP expectations.
module tb_axi4_burst_slave;
    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [3:0]  AWID = '0;
    logic [15:0] AWADDR = '0;
    logic [7:0]  AWLEN = '0;
    logic [2:0]  AWSIZE = '0;
    logic [1:0]  AWBURST = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WLAST = 1'b0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic [3:0]  ARID = '0;
    logic [15:0] ARADDR = '0;
    logic [7:0]  ARLEN = '0;
    logic [2:0]  ARSIZE = '0;
    logic [1:0]  ARBURST = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY = 1'b0;

    int total = 0;
    int bad = 0;
    logic [31:0] wd [4];
    logic [31:0] rd [4];

    axi4_burst_slave #(
        .DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(4), .MEMORY_DEPTH(1024)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
        .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_wd(input logic [31:0] a, b, c, d);
        wd[0] = a; wd[1] = b; wd[2] = c; wd[3] = d;
    endtask

    task automatic set_rd(input logic [31:0] a, b, c, d);
        rd[0] = a; rd[1] = b; rd[2] = c; rd[3] = d;
    endtask

    task automatic do_write(input logic [3:0] id, input logic [15:0] addr,
                            input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] strb,
                            input int last_at, input logic [1:0] exp_resp);
        int n;
        AWID = id; AWADDR = addr; AWLEN = len;
        AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        n = 0;
        while (!AWREADY && n < 50) begin
            step();
            n++;
        end
        check("awready_wait", AWREADY, 1);
        step();
        AWVALID = 1'b0;
        check("aw_drop", AWREADY, 0);
        for (int i = 0; i <= int'(len); i++) begin
            check("wready", WREADY, 1);
            check("bvalid_early", BVALID, 0);
            WVALID = 1'b1;
            WDATA = wd[i];
            WSTRB = strb;
            WLAST = (i == last_at);
            step();
        end
        WVALID = 1'b0;
        WLAST = 1'b0;
        check("wready_off", WREADY, 0);
        check("bvalid", BVALID, 1);
        check("bid", BID, id);
        check("bresp", BRESP, exp_resp);
        BREADY = 1'b1;
        step();
        BREADY = 1'b0;
        check("bvalid_off", BVALID, 0);
        check("awready_back", AWREADY, 1);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [15:0] addr,
                           input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [1:0] exp_resp,
                           input bit stall);
        int n;
        ARID = id; ARADDR = addr; ARLEN = len;
        ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
        n = 0;
        while (!ARREADY && n < 50) begin
            step();
            n++;
        end
        check("arready_wait", ARREADY, 1);
        step();
        ARVALID = 1'b0;
        check("ar_drop", ARREADY, 0);
        check("rvalid_lat1", RVALID, 0);
        step();
        check("rvalid_lat2", RVALID, 1);
        RREADY = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            check("rvalid", RVALID, 1);
            check("rdata", RDATA, rd[i]);
            check("rresp", RRESP, exp_resp);
            check("rlast", RLAST, (i == int'(len)));
            check("rid", RID, id);
            if (stall) begin
                RREADY = 1'b0;
                step();
                check("stall_rvalid", RVALID, 1);
                check("stall_rdata", RDATA, rd[i]);
                check("stall_rlast", RLAST, (i == int'(len)));
                RREADY = 1'b1;
            end
            step();
        end
        RREADY = 1'b0;
        check("rvalid_off", RVALID, 0);
        check("arready_back", ARREADY, 1);
    endtask

    initial begin
        int n;
        step();
        step();
        check("rst_awready", AWREADY, 0);
        check("rst_arready", ARREADY, 0);
        check("rst_wready", WREADY, 0);
        check("rst_bvalid", BVALID, 0);
        check("rst_rvalid", RVALID, 0);
        check("rst_rdata", RDATA, 0);
        check("rst_rlast", RLAST, 0);
        check("rst_bresp", BRESP, 0);
        ARESET = 1'b0;
        check("rel_awready0", AWREADY, 0);
        step();
        check("rel_awready1", AWREADY, 1);
        check("rel_arready1", ARREADY, 1);

        // INCR write then read back
        set_wd(32'hA0, 32'hA1, 32'hA2, 32'hA3);
        do_write(4'd3, 16'h010, 8'd3, 3'd2, 2'b01, 4'hF, 3, 2'b00);
        set_rd(32'hA0, 32'hA1, 32'hA2, 32'hA3);
        do_read(4'd3, 16'h010, 8'd3, 3'd2, 2'b01, 2'b00, 1'b0);

        // known contents for words 0..3
        set_wd(32'hC0, 32'hC1, 32'hC2, 32'hC3);
        do_write(4'd1, 16'h000, 8'd3, 3'd2, 2'b01, 4'hF, 3, 2'b00);

        // WRAP from 0x08: words 2,3,0,1
        set_wd(32'hB0, 32'hB1, 32'hB2, 32'hB3);
`ifdef AXI4_BURST_SLAVE_WRAP_EN
        do_write(4'd2, 16'h008, 8'd3, 3'd2, 2'b10, 4'hF, 3, 2'b00);
        set_rd(32'hB0, 32'hB1, 32'hB2, 32'hB3);
        do_read(4'd2, 16'h008, 8'd3, 3'd2, 2'b10, 2'b00, 1'b0);
        set_rd(32'hB2, 32'hB3, 32'hB0, 32'hB1);
        do_read(4'd2, 16'h000, 8'd3, 3'd2, 2'b01, 2'b00, 1'b0);
`else
        do_write(4'd2, 16'h008, 8'd3, 3'd2, 2'b10, 4'hF, 3, 2'b10);
        set_rd(0, 0, 0, 0);
        do_read(4'd2, 16'h008, 8'd3, 3'd2, 2'b10, 2'b10, 1'b0);
        set_rd(32'hC0, 32'hC1, 32'hC2, 32'hC3);
        do_read(4'd2, 16'h000, 8'd3, 3'd2, 2'b01, 2'b00, 1'b0);
`endif

        // 4 KB boundary: exact fit is fine, crossing is SLVERR with no writes
        set_wd(32'hE0, 32'hE1, 0, 0);
        do_write(4'd4, 16'h0FF8, 8'd1, 3'd2, 2'b01, 4'hF, 1, 2'b00);
        set_wd(32'hD0, 32'hD1, 32'hD2, 32'hD3);
        do_write(4'd4, 16'h0FF8, 8'd3, 3'd2, 2'b01, 4'hF, 3, 2'b10);
        set_rd(32'hE0, 32'hE1, 0, 0);
        do_read(4'd4, 16'h0FF8, 8'd1, 3'd2, 2'b01, 2'b00, 1'b0);

        // beyond MEMORY_DEPTH
        set_rd(0, 0, 0, 0);
        do_read(4'd5, 16'h1000, 8'd0, 3'd2, 2'b01, 2'b11, 1'b0);
        set_wd(32'h77, 0, 0, 0);
        do_write(4'd5, 16'h1000, 8'd0, 3'd2, 2'b01, 4'hF, 0, 2'b11);

        // oversized beat
        do_write(4'd6, 16'h040, 8'd0, 3'd3, 2'b01, 4'hF, 0, 2'b10);

        // byte strobes, then stalled read
        set_wd(32'hFFFF_FFFF, 32'h1234_5678, 0, 0);
        do_write(4'd7, 16'h040, 8'd1, 3'd2, 2'b01, 4'hF, 1, 2'b00);
        set_wd(32'h0, 0, 0, 0);
        do_write(4'd7, 16'h040, 8'd0, 3'd2, 2'b01, 4'b0101, 0, 2'b00);
        set_rd(32'hFF00_FF00, 32'h1234_5678, 0, 0);
        do_read(4'd7, 16'h040, 8'd1, 3'd2, 2'b01, 2'b00, 1'b1);

        // FIXED burst: both beats hit one word
        set_wd(32'h11, 32'h22, 0, 0);
        do_write(4'd10, 16'h0C0, 8'd1, 3'd2, 2'b00, 4'hF, 1, 2'b00);
        set_rd(32'h22, 32'h22, 0, 0);
        do_read(4'd10, 16'h0C0, 8'd1, 3'd2, 2'b00, 2'b00, 1'b0);

        // early WLAST: all beats taken, data kept, SLVERR
        set_wd(32'hF0, 32'hF1, 32'hF2, 32'hF3);
        do_write(4'd8, 16'h080, 8'd3, 3'd2, 2'b01, 4'hF, 1, 2'b10);
        set_rd(32'hF0, 32'hF1, 32'hF2, 32'hF3);
        do_read(4'd8, 16'h080, 8'd3, 3'd2, 2'b01, 2'b00, 1'b0);

        // reset in the middle of a read burst
        ARID = 4'd1; ARADDR = 16'h010; ARLEN = 8'd3;
        ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b1;
        n = 0;
        while (!ARREADY && n < 50) begin
            step();
            n++;
        end
        step();
        ARVALID = 1'b0;
        step();
        check("mid_rvalid", RVALID, 1);
        RREADY = 1'b1;
        step();
        check("mid_rdata1", RDATA, 32'hA1);
        RREADY = 1'b0;
        ARESET = 1'b1;
        step();
        ARESET = 1'b0;
        check("mid_rst_rvalid", RVALID, 0);
        check("mid_rst_arready", ARREADY, 0);
        check("mid_rst_rdata", RDATA, 0);
        step();
        check("mid_post_arready", ARREADY, 1);
        check("mid_post_awready", AWREADY, 1);
        set_rd(32'hA0, 0, 0, 0);
        do_read(4'd9, 16'h010, 8'd0, 3'd2, 2'b01, 2'b00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
